// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: PC defaults, NOP, the AdEL
// exception code and the IF/ID pipeline record.
// Optional feature: FETCH_ADDR_EXC_EN adds exception fields to the record.
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL       = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
`ifdef FETCH_ADDR_EXC_EN
    logic        exc;
    logic [4:0]  exccode;
`endif
  } ifid_t;

  // Empty IF/ID slot: everything zero, not valid.
  function automatic ifid_t ifid_bubble();
    ifid_t v;
    v = '0;
    v.instr = NOP;
    return v;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: pipeline control in, instruction memory handshake,
// IF/ID outputs. FETCH_ADDR_EXC_EN adds the fetch address exception outputs.
interface fetch_if;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        exc_req_i;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc8_o;
  logic        id_valid_o;
`ifdef FETCH_ADDR_EXC_EN
  logic        id_exc_o;
  logic [4:0]  id_exccode_o;
`endif

  // Fetch unit side.
  modport slave (
    input  stall_i, flush_i, redirect_valid_i, redirect_pc_i, exc_req_i, instr_i,
`ifdef FETCH_ADDR_EXC_EN
    output id_exc_o, id_exccode_o,
`endif
    output pc_o, id_instr_o, id_pc_o, id_pc8_o, id_valid_o
  );

  // Pipeline / memory side.
  modport master (
    output stall_i, flush_i, redirect_valid_i, redirect_pc_i, exc_req_i, instr_i,
`ifdef FETCH_ADDR_EXC_EN
    input  id_exc_o, id_exccode_o,
`endif
    input  pc_o, id_instr_o, id_pc_o, id_pc8_o, id_valid_o
  );
endinterface

// File: rtl/npc_sel.sv
// Next-PC selection: exception > stall > redirect > sequential.
module npc_sel #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic [31:0] i_pc,
  input  logic        i_exc_req,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_npc
);

  // Priority mux; PC+4 wraps naturally at 32 bits, redirect target used as given.
  always_comb begin
    o_npc = i_pc + 32'd4;
    if (i_exc_req)             o_npc = EXC_VECTOR;
    else if (i_stall)          o_npc = i_pc;
    else if (i_redirect_valid) o_npc = i_redirect_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC select, IF/ID register.
// Optional feature: FETCH_ADDR_EXC_EN checks the fetch address (alignment
// and window [RESET_PC, RESET_PC+4095]) and flags AdEL in IF/ID.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.slave  bus
);

  logic [31:0] r_pc;
  logic [31:0] w_npc;
  ifid_t       r_ifid;
  ifid_t       w_ifid_next;
  ifid_t       w_fetch;

  npc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_npc_sel (
    .i_pc             (r_pc),
    .i_exc_req        (bus.exc_req_i),
    .i_stall          (bus.stall_i),
    .i_redirect_valid (bus.redirect_valid_i),
    .i_redirect_pc    (bus.redirect_pc_i),
    .o_npc            (w_npc)
  );

`ifdef FETCH_ADDR_EXC_EN
  logic w_addr_bad;

  // Misaligned or outside the 4 KiB fetch window; 33-bit compare avoids wrap.
  always_comb begin
    w_addr_bad = (r_pc[1:0] != 2'b00) ||
                 (r_pc < RESET_PC) ||
                 ({1'b0, r_pc} > ({1'b0, RESET_PC} + 33'd4095));
  end
`endif

  // Record for the instruction currently being fetched.
  always_comb begin
    w_fetch       = ifid_bubble();
    w_fetch.instr = bus.instr_i;
    w_fetch.pc    = r_pc;
    w_fetch.pc8   = r_pc + 32'd8;
    w_fetch.valid = 1'b1;
`ifdef FETCH_ADDR_EXC_EN
    if (w_addr_bad) begin
      w_fetch.instr   = NOP;
      w_fetch.exc     = 1'b1;
      w_fetch.exccode = EXC_ADEL;
    end
`endif
  end

  // IF/ID next value: exception or flush bubble beats stall; redirect keeps the delay slot.
  always_comb begin
    w_ifid_next = w_fetch;
    if (bus.exc_req_i || bus.flush_i) w_ifid_next = ifid_bubble();
    else if (bus.stall_i)             w_ifid_next = r_ifid;
  end

  // PC and IF/ID registers; reset drops any pending stall or redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_ifid <= ifid_bubble();
    end else begin
      r_pc   <= w_npc;
      r_ifid <= w_ifid_next;
    end
  end

  assign bus.pc_o       = r_pc;
  assign bus.id_instr_o = r_ifid.instr;
  assign bus.id_pc_o    = r_ifid.pc;
  assign bus.id_pc8_o   = r_ifid.pc8;
  assign bus.id_valid_o = r_ifid.valid;
`ifdef FETCH_ADDR_EXC_EN
  assign bus.id_exc_o     = r_ifid.exc;
  assign bus.id_exccode_o = r_ifid.exccode;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expected values written out by hand.
// Instruction memory is modelled as instr = pc ^ 32'hDEAD_0000.
module tb_fetch_unit;

  localparam logic [31:0] MASK = 32'hDEAD_0000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fetch_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr_i = bus.pc_o ^ MASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h3FFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check pc_o and the IF/ID contents; valid=0 means a bubble is expected.
  task automatic expect_state(input string tag, input logic [31:0] pc,
                              input logic [31:0] id_pc, input logic valid);
    logic [31:0] e_instr;
    chk({tag, ".pc"}, bus.pc_o, pc);
    chk({tag, ".valid"}, {31'd0, bus.id_valid_o}, {31'd0, valid});
    chk({tag, ".id_pc"}, bus.id_pc_o, valid ? id_pc : 32'h0);
    chk({tag, ".pc8"}, bus.id_pc8_o, valid ? id_pc + 32'd8 : 32'h0);
    e_instr = valid ? (id_pc ^ MASK) : 32'h0;
`ifdef FETCH_ADDR_EXC_EN
    if (valid && addr_bad(id_pc)) e_instr = 32'h0;
    chk({tag, ".exc"}, {31'd0, bus.id_exc_o}, {31'd0, valid && addr_bad(id_pc)});
    chk({tag, ".code"}, {27'd0, bus.id_exccode_o},
        (valid && addr_bad(id_pc)) ? 32'd4 : 32'd0);
`endif
    chk({tag, ".instr"}, bus.id_instr_o, e_instr);
  endtask

  task automatic drive(input logic st, input logic fl, input logic rv,
                       input logic [31:0] rpc, input logic ex);
    bus.stall_i          = st;
    bus.flush_i          = fl;
    bus.redirect_valid_i = rv;
    bus.redirect_pc_i    = rpc;
    bus.exc_req_i        = ex;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 0);
    #12;
    expect_state("rst", 32'h3000, 32'h0, 0);
    @(negedge clk);
    reset = 1'b1;

    tick(); expect_state("seq1", 32'h3004, 32'h3000, 1);
    tick(); expect_state("seq2", 32'h3008, 32'h3004, 1);

    drive(1, 0, 0, 32'h0, 0);
    tick(); expect_state("stall1", 32'h3008, 32'h3004, 1);
    tick(); expect_state("stall2", 32'h3008, 32'h3004, 1);
    drive(0, 0, 0, 32'h0, 0);
    tick(); expect_state("resume", 32'h300C, 32'h3008, 1);
    tick(); expect_state("seq3", 32'h3010, 32'h300C, 1);

    drive(1, 0, 1, 32'h3100, 0);
    tick(); expect_state("redir_stall", 32'h3010, 32'h300C, 1);
    drive(0, 0, 1, 32'h3100, 0);
    tick(); expect_state("redir", 32'h3100, 32'h3010, 1);
    drive(0, 0, 0, 32'h0, 0);
    tick(); expect_state("after_redir", 32'h3104, 32'h3100, 1);

    drive(1, 1, 0, 32'h0, 0);
    tick(); expect_state("flush_stall", 32'h3104, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0);
    tick(); expect_state("after_flush", 32'h3108, 32'h3104, 1);

    drive(1, 0, 0, 32'h0, 1);
    tick(); expect_state("exc", 32'h4180, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0);
    tick(); expect_state("after_exc", 32'h4184, 32'h4180, 1);

    drive(0, 0, 1, 32'h3002, 0);
    tick(); expect_state("redir_unal", 32'h3002, 32'h4184, 1);
    drive(0, 0, 0, 32'h0, 0);
    tick(); expect_state("unal_fetch", 32'h3006, 32'h3002, 1);

    drive(0, 0, 1, 32'hFFFF_FFFC, 0);
    tick(); expect_state("redir_top", 32'hFFFF_FFFC, 32'h3006, 1);
    drive(0, 0, 0, 32'h0, 0);
    tick(); expect_state("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 1);
    tick(); expect_state("post_wrap", 32'h0000_0004, 32'h0000_0000, 1);

    drive(0, 0, 1, 32'h3100, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 expect_state("async_rst", 32'h3000, 32'h0, 0);
    tick(); expect_state("rst_hold", 32'h3000, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(); expect_state("rst_rel", 32'h3004, 32'h3000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, PC loaded on exception entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_i  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush_i  input  1  load bubble into IF/ID.
REQ-007 SHALL have port redirect_valid_i  input  1  branch/jump taken, resolved in ID.
REQ-008 SHALL have port redirect_pc_i  input  32  branch/jump target.
REQ-009 SHALL have port exc_req_i  input  1  exception entry request from a later stage.
REQ-010 SHALL have port pc_o  output  32  current fetch PC, driven to instruction memory.
REQ-011 SHALL have port instr_i  input  32  combinational instruction memory word for pc_o.
REQ-012 SHALL have ports id_instr_o, id_pc_o, id_pc8_o  output  32 each  IF/ID instruction, its PC, and PC+8 (link value).
REQ-013 SHALL have port id_valid_o  output  1  IF/ID holds a real instruction.

Function
REQ-014 Next-PC priority SHALL be: exc_req_i > stall_i > redirect_valid_i > sequential (PC+4).
REQ-015 exc_req_i=1 SHALL load PC<=EXC_VECTOR and bubble IF/ID in the same edge, regardless of stall_i.
REQ-016 stall_i=1 (no exc) SHALL hold PC and all IF/ID outputs unchanged; redirect_valid_i SHALL be ignored that cycle.
REQ-017 redirect_valid_i=1 (no stall, no exc) SHALL load PC<=redirect_pc_i; IF/ID SHALL still capture the current fetch (delay slot), no flush.
REQ-018 Otherwise PC SHALL advance to PC+4, modulo 2^32 (wrap 32'hFFFF_FFFC -> 0).
REQ-019 IF/ID SHALL capture {instr_i, pc_o, pc_o+8, valid=1} on each non-stalled, non-flushed edge; one-cycle latency from pc_o to id_*_o.
REQ-020 flush_i=1 SHALL load bubble {instr=0, pc=0, pc8=0, valid=0}; flush_i SHALL override stall_i for IF/ID only; PC obeys REQ-014.
REQ-021 PC arithmetic SHALL be unsigned 32-bit; redirect_pc_i SHALL be used unaligned-as-given (no masking).

Reset
REQ-022 reset=0 SHALL asynchronously set PC=RESET_PC and IF/ID to bubble (all zeros, id_valid_o=0).
REQ-023 Reset deassertion SHALL make pc_o=RESET_PC valid for the first clock edge; first id_valid_o=1 one edge later.
REQ-024 Reset mid-stall or mid-redirect SHALL discard pending state; no redirect survives reset.

Configuration
REQ-025 Macro FETCH_ADDR_EXC_EN SHALL enable fetch address checking.
REQ-026 With FETCH_ADDR_EXC_EN: pc_o[1:0]!=0 or pc_o outside [RESET_PC, RESET_PC+4095] SHALL capture instr=0 and assert extra output id_exc_o=1 with id_exccode_o=5'd4 (AdEL); both cleared by bubble/reset.
REQ-027 Without FETCH_ADDR_EXC_EN: no check, ports id_exc_o/id_exccode_o SHALL not exist.

Structure
REQ-028 Shared package fetch_pkg SHALL hold RESET_PC/EXC_VECTOR defaults, NOP (32'h0), EXC_ADEL (5'd4) and the IF/ID record typedef.
REQ-029 Next-PC selection SHALL be one combinational sub-module npc_sel; PC and IF/ID registers stay in fetch_unit.

Verification
REQ-030 Reset released, 3 free edges -> pc_o 3000,3004,3008,300C; id_pc_o 3000,3004,3008 with id_valid_o=1, id_pc8_o=id_pc_o+8.
REQ-031 stall_i=1 for 2 cycles at pc_o=3008 -> pc_o and id_* frozen; resume -> 300C next, no skipped/duplicated IF/ID entry.
REQ-032 redirect_valid_i=1, redirect_pc_i=3100 at pc_o=3010 -> id_pc_o=3010 (delay slot), pc_o=3100 next; same with stall_i=1 -> redirect ignored.
REQ-033 exc_req_i=1 with stall_i=1 and flush_i=0 -> pc_o=4180, id_valid_o=0, id_instr_o=0 next edge.
REQ-034 reset pulled low mid-cycle during redirect -> pc_o=3000 immediately (no clock), id_valid_o=0.
REQ-035 FETCH_ADDR_EXC_EN, redirect to 3002 -> next IF/ID id_exc_o=1, id_exccode_o=4, id_instr_o=0; without macro -> normal capture.
